io_reset_requester: RTL and testbench

Memory-mapped front end that turns CPU reset-request commands into the single-cycle `SoftwareReset` strobe and the held one-hot reset vector consumed by the memory flasher. It tracks the flasher's handshake (response or full-reset trigger), enforces a timeout and returns a completion status to the CPU. It sits between the IO interconnect and the flasher's `SoftwareResetIn`/`ResetVectorIn` inputs, in the system-control domain.

---
 rtl/io_reset_requester_pkg.sv | 29 ++
 rtl/reset_vector_prio_enc.sv | 27 ++
 rtl/io_reset_requester.sv | 139 +++++++++++++
 tb/tb_io_reset_requester.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_reset_requester_pkg.sv
// Shared definitions for the IO reset requester.
//   rr_state_t  : control FSM states
//   RR_*        : 2-bit completion status codes placed in IORespData[15:14]
//   RV_*        : bit positions inside the 4-bit reset vector {Full, Inst, IO, Data}
//   rr_word()   : packs a status code and a vector into the 16-bit response word
package io_reset_requester_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } rr_state_t;

    localparam logic [1:0] RR_OK       = 2'b00;
    localparam logic [1:0] RR_TIMEOUT  = 2'b01;
    localparam logic [1:0] RR_INVALID  = 2'b10;
    localparam logic [1:0] RR_DISABLED = 2'b11;

    localparam int RV_FULL = 3;
    localparam int RV_INST = 2;
    localparam int RV_IO   = 1;
    localparam int RV_DATA = 0;

    function automatic logic [15:0] rr_word(input logic [1:0] code, input logic [3:0] vec);
        return {code, 10'd0, vec};
    endfunction

endpackage

// File: rtl/reset_vector_prio_enc.sv
// Reset vector priority encoder.
// Reduces a multi-hot {Full, Inst, IO, Data} request to a one-hot vector,
// keeping only the most severe request (Full > Inst > IO > Data).
// Ports:
//   multiHot in  4 : requested vector, any combination of bits
//   oneHot   out 4 : single highest-priority bit, or 0 when nothing requested
module reset_vector_prio_enc
    import io_reset_requester_pkg::*;
(
    input  logic [3:0] multiHot,
    output logic [3:0] oneHot
);

    always_comb begin
        oneHot = '0;
        if (multiHot[RV_FULL]) begin
            oneHot[RV_FULL] = 1'b1;
        end else if (multiHot[RV_INST]) begin
            oneHot[RV_INST] = 1'b1;
        end else if (multiHot[RV_IO]) begin
            oneHot[RV_IO] = 1'b1;
        end else if (multiHot[RV_DATA]) begin
            oneHot[RV_DATA] = 1'b1;
        end
    end

endmodule

// File: rtl/io_reset_requester.sv
// IO reset requester.
// Accepts CPU commands from the IO interconnect, issues a one-cycle
// SoftwareReset strobe with a held one-hot vector to the memory flasher,
// waits for the flasher's reply (or full-system trigger, or timeout) and
// returns a 16-bit completion word {status[1:0], 10'b0, vector[3:0]}.
// Ports:
//   clk, async_rst_n            : clock, asynchronous active-low reset
//   clk_en                      : global enable, nothing advances while low
//   IOCmdValid/Ready/Write/Data : command channel (Write=1 request, 0 status read)
//   IORespValid/Ready/Data      : response channel
//   SystemEnableIn              : flasher system enable
//   SoftwareResetOut            : one clk_en-cycle reset strobe
//   ResetVectorOut              : one-hot vector, held strobe..completion
//   ResetResponseIn             : flasher completion reply
//   ResetTriggerIn              : flasher full-system reset trigger
module io_reset_requester
    import io_reset_requester_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        async_rst_n,
    input  logic        clk_en,
    input  logic        IOCmdValid,
    output logic        IOCmdReady,
    input  logic        IOCmdWrite,
    input  logic [3:0]  IOCmdData,
    output logic        IORespValid,
    input  logic        IORespReady,
    output logic [15:0] IORespData,
    input  logic        SystemEnableIn,
    output logic        SoftwareResetOut,
    output logic [3:0]  ResetVectorOut,
    input  logic        ResetResponseIn,
    input  logic        ResetTriggerIn
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    rr_state_t        stateReg;
    logic [CNT_W-1:0] timeoutCnt;
    logic [15:0]      lastWord;     // last completion word returned by status reads
    logic             respIsRead;   // current response answers a status read
    logic [3:0]       cmdOneHot;

    reset_vector_prio_enc u_prio_enc (
        .multiHot (IOCmdData),
        .oneHot   (cmdOneHot)
    );

    // Only output that is not a register: a direct decode of the state.
    assign IOCmdReady = (stateReg == IDLE);

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            stateReg         <= IDLE;
            timeoutCnt       <= '0;
            lastWord         <= '0;
            respIsRead       <= 1'b0;
            IORespValid      <= 1'b0;
            IORespData       <= '0;
            SoftwareResetOut <= 1'b0;
            ResetVectorOut   <= '0;
        end else if (clk_en) begin
            // The strobe only survives the single ISSUE cycle; with clk_en low
            // this block is skipped so it holds until the next enabled edge.
            SoftwareResetOut <= 1'b0;

            unique case (stateReg)
                IDLE: begin
                    if (IOCmdValid) begin
                        if (!IOCmdWrite) begin
                            respIsRead  <= 1'b1;
                            IORespData  <= lastWord;
                            IORespValid <= 1'b1;
                            stateReg    <= RESPOND;
                        end else if (IOCmdData == 4'd0) begin
                            respIsRead  <= 1'b0;
                            IORespData  <= rr_word(RR_INVALID, 4'd0);
                            IORespValid <= 1'b1;
                            stateReg    <= RESPOND;
                        end else if (!SystemEnableIn) begin
                            respIsRead  <= 1'b0;
                            IORespData  <= rr_word(RR_DISABLED, 4'd0);
                            IORespValid <= 1'b1;
                            stateReg    <= RESPOND;
                        end else begin
                            respIsRead       <= 1'b0;
                            ResetVectorOut   <= cmdOneHot;
                            timeoutCnt       <= '0;
                            SoftwareResetOut <= 1'b1;
                            stateReg         <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    stateReg <= WAIT;
                end

                WAIT: begin
                    // Trigger beats response; response beats a timeout landing
                    // on the same cycle.
                    if (ResetTriggerIn) begin
                        lastWord       <= rr_word(RR_OK, ResetVectorOut);
                        ResetVectorOut <= '0;
                        stateReg       <= IDLE;
                    end else if (ResetResponseIn) begin
                        IORespData  <= rr_word(RR_OK, ResetVectorOut);
                        IORespValid <= 1'b1;
                        stateReg    <= RESPOND;
                    end else if (timeoutCnt == CNT_LAST) begin
                        IORespData  <= rr_word(RR_TIMEOUT, ResetVectorOut);
                        IORespValid <= 1'b1;
                        stateReg    <= RESPOND;
                    end else begin
                        timeoutCnt <= timeoutCnt + CNT_W'(1);
                    end
                end

                RESPOND: begin
                    if (IORespReady) begin
                        if (!respIsRead) begin
                            lastWord <= IORespData;
                        end
                        IORespValid    <= 1'b0;
                        IORespData     <= '0;
                        ResetVectorOut <= '0;
                        stateReg       <= IDLE;
                    end
                end

                default: stateReg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_reset_requester.sv
module tb_io_reset_requester;

    localparam int TO = 24;

    logic        clk;
    logic        async_rst_n;
    logic        clk_en;
    logic        IOCmdValid;
    logic        IOCmdReady;
    logic        IOCmdWrite;
    logic [3:0]  IOCmdData;
    logic        IORespValid;
    logic        IORespReady;
    logic [15:0] IORespData;
    logic        SystemEnableIn;
    logic        SoftwareResetOut;
    logic [3:0]  ResetVectorOut;
    logic        ResetResponseIn;
    logic        ResetTriggerIn;

    int passCnt  = 0;
    int totalCnt = 0;
    int strobeCnt = 0;
    int txnNum = 0;
    logic gate = 1'b0;
    logic [15:0] modelLast = 16'h0000;   // reference model of the completion word

    io_reset_requester #(.TIMEOUT_CYCLES(TO)) dut (
        .clk              (clk),
        .async_rst_n      (async_rst_n),
        .clk_en           (clk_en),
        .IOCmdValid       (IOCmdValid),
        .IOCmdReady       (IOCmdReady),
        .IOCmdWrite       (IOCmdWrite),
        .IOCmdData        (IOCmdData),
        .IORespValid      (IORespValid),
        .IORespReady      (IORespReady),
        .IORespData       (IORespData),
        .SystemEnableIn   (SystemEnableIn),
        .SoftwareResetOut (SoftwareResetOut),
        .ResetVectorOut   (ResetVectorOut),
        .ResetResponseIn  (ResetResponseIn),
        .ResetTriggerIn   (ResetTriggerIn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe cycles as the flasher sees them (only enabled edges count).
    always @(posedge clk) begin
        if (async_rst_n && clk_en && SoftwareResetOut) strobeCnt++;
    end

    // Highest set bit of the request, computed arithmetically.
    function automatic logic [3:0] exp_onehot(input logic [3:0] d);
        int msb;
        msb = $clog2(int'(d) + 1) - 1;
        return 4'(1 << msb);
    endfunction

    // One enabled clock edge; in gated mode two disabled edges come first and
    // every output must hold across them.
    task automatic tick();
        logic [22:0] snap;
        if (gate) begin
            snap = {SoftwareResetOut, ResetVectorOut, IORespValid, IORespData, IOCmdReady};
            clk_en = 1'b0;
            repeat (2) begin @(posedge clk); #1; end
            totalCnt++;
            if ({SoftwareResetOut, ResetVectorOut, IORespValid, IORespData, IOCmdReady} !== snap)
                $display("FAIL gated_hold: got %h want %h",
                         {SoftwareResetOut, ResetVectorOut, IORespValid, IORespData, IOCmdReady}, snap);
            else passCnt++;
        end
        clk_en = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic send_cmd(input logic wr, input logic [3:0] d);
        int i;
        IOCmdValid = 1'b1; IOCmdWrite = wr; IOCmdData = d;
        i = 0;
        while (!IOCmdReady && i < 10) begin tick(); i++; end
        totalCnt++;
        if (!IOCmdReady) $display("FAIL cmd_ready_timeout: got %b want 1", IOCmdReady);
        else passCnt++;
        tick();
        IOCmdValid = 1'b0;
    endtask

    // Response handshake with `hold` cycles of back-pressure.
    task automatic respond(input int hold, input logic [15:0] ew);
        int bad;
        bad = 0;
        IORespReady = 1'b0;
        for (int h = 0; h < hold; h++) begin
            tick();
            if (IORespValid !== 1'b1 || IORespData !== ew) bad++;
        end
        totalCnt++;
        if (bad != 0) $display("FAIL resp_stable: got %0d unstable cycles want 0 (data %h want %h)", bad, IORespData, ew);
        else passCnt++;
        IORespReady = 1'b1;
        tick();
        IORespReady = 1'b0;
        totalCnt++;
        if (IORespValid !== 1'b0 || ResetVectorOut !== 4'd0 || IOCmdReady !== 1'b1)
            $display("FAIL resp_done: got valid=%b vec=%b ready=%b want 0/0000/1", IORespValid, ResetVectorOut, IOCmdReady);
        else passCnt++;
    endtask

    task automatic do_read(input int hold);
        send_cmd(1'b0, 4'($urandom_range(0, 15)));
        totalCnt++;
        if (IORespValid !== 1'b1 || IORespData !== modelLast)
            $display("FAIL read_data: got valid=%b data=%h want 1/%h", IORespValid, IORespData, modelLast);
        else passCnt++;
        respond(hold, modelLast);
        txnNum++;
        $display("txn %0d: read -> %h", txnNum, modelLast);
    endtask

    // mode 0: flasher reply after `delay` WAIT cycles, 1: trigger, 2: no reply
    task automatic do_request(input logic [3:0] d, input logic en, input int mode, input int delay, input int hold);
        logic [3:0]  ev;
        logic [15:0] ew;
        int s0, n, bad;
        SystemEnableIn = en;
        s0 = strobeCnt;
        send_cmd(1'b1, d);
        if (d == 4'd0 || !en) begin
            ew = (d == 4'd0) ? 16'h8000 : 16'hC000;
            totalCnt++;
            if (IORespValid !== 1'b1 || IORespData !== ew || SoftwareResetOut !== 1'b0)
                $display("FAIL reject_resp: got valid=%b data=%h strobe=%b want 1/%h/0", IORespValid, IORespData, SoftwareResetOut, ew);
            else passCnt++;
            respond(hold, ew);
            modelLast = ew;
        end else begin
            ev = exp_onehot(d);
            totalCnt++;
            if (SoftwareResetOut !== 1'b1 || ResetVectorOut !== ev)
                $display("FAIL strobe_vec: got strobe=%b vec=%b want 1/%b", SoftwareResetOut, ResetVectorOut, ev);
            else passCnt++;
            tick();
            totalCnt++;
            if (SoftwareResetOut !== 1'b0) $display("FAIL strobe_width: got %b want 0", SoftwareResetOut);
            else passCnt++;
            if (mode == 2) begin
                n = 0;
                while (!IORespValid && n < TO + 4) begin tick(); n++; end
                ew = {2'b01, 10'd0, ev};
                totalCnt++;
                if (n != TO || IORespData !== ew)
                    $display("FAIL timeout: got %0d cycles data=%h want %0d cycles data=%h", n, IORespData, TO, ew);
                else passCnt++;
                respond(hold, ew);
                modelLast = ew;
            end else begin
                repeat (delay) tick();
                totalCnt++;
                if (IORespValid !== 1'b0 || ResetVectorOut !== ev)
                    $display("FAIL wait_state: got valid=%b vec=%b want 0/%b", IORespValid, ResetVectorOut, ev);
                else passCnt++;
                if (mode == 1) begin
                    ResetTriggerIn = 1'b1;
                    ResetResponseIn = 1'($urandom_range(0, 1));
                    tick();
                    ResetTriggerIn = 1'b0; ResetResponseIn = 1'b0;
                    bad = 0;
                    for (int k = 0; k < 3; k++) begin
                        if (IORespValid !== 1'b0 || IOCmdReady !== 1'b1) bad++;
                        tick();
                    end
                    totalCnt++;
                    if (bad != 0) $display("FAIL trigger_idle: got %0d bad cycles want 0", bad);
                    else passCnt++;
                    ew = {2'b00, 10'd0, ev};
                    modelLast = ew;
                end else begin
                    ResetResponseIn = 1'b1;
                    tick();
                    ResetResponseIn = 1'b0;
                    ew = {2'b00, 10'd0, ev};
                    totalCnt++;
                    if (IORespValid !== 1'b1 || IORespData !== ew)
                        $display("FAIL ok_resp: got valid=%b data=%h want 1/%h", IORespValid, IORespData, ew);
                    else passCnt++;
                    respond(hold, ew);
                    modelLast = ew;
                end
            end
        end
        totalCnt++;
        if (strobeCnt - s0 != ((d != 4'd0 && en) ? 1 : 0))
            $display("FAIL strobe_count: got %0d want %0d", strobeCnt - s0, (d != 4'd0 && en) ? 1 : 0);
        else passCnt++;
        txnNum++;
        $display("txn %0d: write %b en=%b mode=%0d delay=%0d -> %h", txnNum, d, en, mode, delay, modelLast);
    endtask

    task automatic test_reset();
        totalCnt++;
        if (IOCmdReady !== 1'b1 || IORespValid !== 1'b0 || IORespData !== 16'h0 ||
            SoftwareResetOut !== 1'b0 || ResetVectorOut !== 4'h0)
            $display("FAIL reset_state: got rdy=%b v=%b d=%h s=%b vec=%b want 1/0/0000/0/0000",
                     IOCmdReady, IORespValid, IORespData, SoftwareResetOut, ResetVectorOut);
        else passCnt++;
        async_rst_n = 1'b1;
        tick();
        do_read(0);   // completion word starts at zero
    endtask

    task automatic test_ok_fixed();
        do_request(4'b0011, 1'b1, 0, 19, 0);   // reply 20 cycles after the strobe
    endtask

    task automatic test_trigger();
        do_request(4'b1000, 1'b1, 1, 4, 0);
        do_read(1);
    endtask

    task automatic test_timeout();
        do_request(4'b0001, 1'b1, 2, 0, 0);
    endtask

    task automatic test_invalid_disabled();
        do_request(4'b0000, 1'b1, 0, 0, 0);
        do_request(4'b0100, 1'b0, 0, 0, 0);
        do_request(4'b0000, 1'b0, 0, 0, 0);
        do_read(0);
    endtask

    task automatic test_boundary();
        do_request(4'b1111, 1'b1, 0, TO - 1, 0);   // reply on the timeout cycle
        do_request(4'b0110, 1'b1, 0, 0, 0);        // reply on first WAIT cycle
    endtask

    task automatic test_clk_en_gating();
        gate = 1'b1;
        do_request(4'b0110, 1'b1, 0, 3, 5);
        gate = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 4) == 0) do_read($urandom_range(0, 3));
            else do_request(4'($urandom_range(0, 15)), 1'($urandom_range(0, 4) != 0),
                            $urandom_range(0, 2), $urandom_range(0, TO - 1), $urandom_range(0, 3));
        end
    endtask

    task automatic test_async_reset();
        int bad;
        SystemEnableIn = 1'b1;
        send_cmd(1'b1, 4'b0100);
        repeat (4) tick();
        #2 async_rst_n = 1'b0;
        #1;
        totalCnt++;
        if (IOCmdReady !== 1'b1 || IORespValid !== 1'b0 || IORespData !== 16'h0 ||
            SoftwareResetOut !== 1'b0 || ResetVectorOut !== 4'h0)
            $display("FAIL async_reset: got rdy=%b v=%b d=%h s=%b vec=%b want 1/0/0000/0/0000",
                     IOCmdReady, IORespValid, IORespData, SoftwareResetOut, ResetVectorOut);
        else passCnt++;
        ResetResponseIn = 1'b1;
        tick();
        async_rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (IORespValid !== 1'b0 || IOCmdReady !== 1'b1 || SoftwareResetOut !== 1'b0) bad++;
        end
        ResetResponseIn = 1'b0;
        totalCnt++;
        if (bad != 0) $display("FAIL post_reset_quiet: got %0d bad cycles want 0", bad);
        else passCnt++;
        modelLast = 16'h0000;
        do_read(0);
    endtask

    initial begin
        async_rst_n = 1'b0; clk_en = 1'b1;
        IOCmdValid = 1'b0; IOCmdWrite = 1'b0; IOCmdData = 4'd0;
        IORespReady = 1'b0; SystemEnableIn = 1'b1;
        ResetResponseIn = 1'b0; ResetTriggerIn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_ok_fixed();
        test_trigger();
        test_timeout();
        test_invalid_disabled();
        test_boundary();
        test_clk_en_gating();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
